uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_if.sv | 13 +
 rtl/uart_rx.sv | 176 +++++++++++++++++
 tb/tb_uart_rx.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Serial receive bundle: the line input plus the received-byte outputs.
interface uart_rx_if;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    // Receiver side: samples the line, drives the results.
    modport slave  (input rx, output rx_data, output rx_valid, output frame_err, output busy);
    // Line driver side: drives the line, observes the results.
    modport master (output rx, input rx_data, input rx_valid, input frame_err, input busy);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: double-flop synchronizer, start-edge detect, mid-bit
// sampling driven by a bit-period down-counter, one-cycle valid/error pulses.
module uart_rx #(
    parameter int FCLK = 100000000,
    parameter int BAUD = 115200
) (
    input  logic      clk,
    input  logic      rst_n,
    uart_rx_if.slave  bus
);
    localparam int N  = FCLK / BAUD;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(N - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(N / 2 - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    logic          r_sync1;
    logic          r_rxs;
    logic          r_prev_rxs;
    logic          w_fall;

    logic [CW-1:0] r_cnt;
    logic          w_cnt_zero;
    logic          w_load;
    logic [CW-1:0] w_load_val;

    state_t        r_state;
    state_t        w_state_next;

    logic [7:0]    r_shift;
    logic [2:0]    r_bitcnt;
    logic          w_shift_en;
    logic          w_bitcnt_clr;
    logic          w_valid_set;
    logic          w_ferr_set;

    logic [7:0]    r_rx_data;
    logic          r_rx_valid;
    logic          r_frame_err;

    assign w_fall     = r_prev_rxs & ~r_rxs;
    assign w_cnt_zero = (r_cnt == '0);

    // Bring the asynchronous line into the clock domain and keep a delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1    <= 1'b1;
            r_rxs      <= 1'b1;
            r_prev_rxs <= 1'b1;
        end else begin
            r_sync1    <= bus.rx;
            r_rxs      <= r_sync1;
            r_prev_rxs <= r_rxs;
        end
    end

    // Bit-period counter: loads on request, otherwise counts down and parks at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= BIT_LOAD;
        end else if (w_load) begin
            r_cnt <= w_load_val;
        end else if (!w_cnt_zero) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and datapath control; every sample decision is taken when the counter hits zero.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_load_val   = BIT_LOAD;
        w_shift_en   = 1'b0;
        w_bitcnt_clr = 1'b0;
        w_valid_set  = 1'b0;
        w_ferr_set   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Only a fresh 1->0 transition starts a frame; a line parked low does not.
                if (w_fall) begin
                    w_load       = 1'b1;
                    w_load_val   = HALF_LOAD;
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                if (w_cnt_zero) begin
                    if (!r_rxs) begin
                        w_load       = 1'b1;
                        w_bitcnt_clr = 1'b1;
                        w_state_next = ST_DATA;
                    end else begin
                        // Line went back high before mid-start: treat as a glitch.
                        w_state_next = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (w_cnt_zero) begin
                    w_shift_en = 1'b1;
                    w_load     = 1'b1;
                    if (r_bitcnt == 3'd7) begin
                        w_state_next = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                // Leave at mid-stop-bit so the next start edge is seen even with no idle gap.
                if (w_cnt_zero) begin
                    w_state_next = ST_IDLE;
                    if (r_rxs) begin
                        w_valid_set = 1'b1;
                    end else begin
                        w_ferr_set = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Shift register and bit counter: LSB arrives first, so shift right into the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift  <= 8'h00;
            r_bitcnt <= 3'd0;
        end else begin
            if (w_shift_en) begin
                r_shift <= {r_rxs, r_shift[7:1]};
            end
            if (w_bitcnt_clr) begin
                r_bitcnt <= 3'd0;
            end else if (w_shift_en) begin
                r_bitcnt <= r_bitcnt + 3'd1;
            end
        end
    end

    // Registered result pulses; the data register only moves on a good stop bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_valid  <= w_valid_set;
            r_frame_err <= w_ferr_set;
            if (w_valid_set) begin
                r_rx_data <= r_shift;
            end
        end
    end

    assign bus.rx_data   = r_rx_data;
    assign bus.rx_valid  = r_rx_valid;
    assign bus.frame_err = r_frame_err;
    assign bus.busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serial frames are driven on the line, the expected
// outcome of each frame is queued, and a monitor pops and checks every pulse.
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int FCLK = 1200000;
    localparam int BAUD = 100000;
    localparam int N    = FCLK / BAUD;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
    } exp_t;

    logic clk;
    logic rst_n;
    uart_rx_if u_if ();

    uart_rx #(.FCLK(FCLK), .BAUD(BAUD)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    int         n_vectors;
    int         n_miscompares;
    int         n_valid;
    int         n_ferr;
    exp_t       sb_q[$];
    exp_t       mon_e;
    logic [7:0] mon_prev_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (u_if.rx_valid && u_if.frame_err) begin
                n_vectors++;
                n_miscompares++;
                $display("FAIL pulse_exclusive: rx_valid and frame_err both high at %0t", $time);
            end
            if (u_if.rx_valid || u_if.frame_err) begin
                if (u_if.rx_valid) n_valid++;
                if (u_if.frame_err) n_ferr++;
                n_vectors++;
                if (sb_q.size() == 0) begin
                    n_miscompares++;
                    $display("FAIL unexpected_pulse: valid=%0b ferr=%0b data=%02h, expected no pulse",
                             u_if.rx_valid, u_if.frame_err, u_if.rx_data);
                end else begin
                    mon_e = sb_q.pop_front();
                    if (u_if.frame_err !== mon_e.is_err || u_if.rx_data !== mon_e.data) begin
                        n_miscompares++;
                        $display("FAIL frame_result: got ferr=%0b data=%02h, expected ferr=%0b data=%02h",
                                 u_if.frame_err, u_if.rx_data, mon_e.is_err, mon_e.data);
                    end else begin
                        $display("frame: ferr=%0b data=%02h ok", u_if.frame_err, u_if.rx_data);
                    end
                end
            end
            if (u_if.rx_data !== mon_prev_data && !u_if.rx_valid) begin
                n_vectors++;
                n_miscompares++;
                $display("FAIL data_stable: rx_data %02h -> %02h without rx_valid",
                         mon_prev_data, u_if.rx_data);
            end
        end
        mon_prev_data = u_if.rx_data;
    end

    // Advance n clock edges, ending just after a rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        u_if.rx = 1'b0;
        step(N);
        for (int i = 0; i < 8; i++) begin
            u_if.rx = d[i];
            step(N);
        end
        u_if.rx = stop;
        step(N);
        u_if.rx = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        u_if.rx = 1'b1;
        step(3);
        n_vectors++;
        if (u_if.rx_data !== 8'h00 || u_if.rx_valid !== 1'b0 ||
            u_if.frame_err !== 1'b0 || u_if.busy !== 1'b0) begin
            n_miscompares++;
            $display("FAIL reset_values: data=%02h valid=%0b ferr=%0b busy=%0b, expected 00 0 0 0",
                     u_if.rx_data, u_if.rx_valid, u_if.frame_err, u_if.busy);
        end else $display("reset: outputs cleared ok");
        rst_n = 1'b1;
        step(3 * N);
        n_vectors++;
        if (u_if.busy !== 1'b0 || n_valid !== 0 || n_ferr !== 0) begin
            n_miscompares++;
            $display("FAIL reset_release_idle: busy=%0b valid_cnt=%0d ferr_cnt=%0d, expected 0 0 0",
                     u_if.busy, n_valid, n_ferr);
        end else $display("reset release: stays idle ok");
    endtask

    task automatic test_single();
        int v0, f0;
        v0 = n_valid; f0 = n_ferr;
        sb_q.push_back('{is_err: 1'b0, data: 8'hA5});
        send_byte(8'hA5, 1'b1);
        step(2 * N);
        n_vectors++;
        if (n_valid - v0 !== 1 || n_ferr - f0 !== 0) begin
            n_miscompares++;
            $display("FAIL single_counts: valid=%0d ferr=%0d, expected 1 0", n_valid - v0, n_ferr - f0);
        end else $display("single 0xA5: counts ok");
    endtask

    task automatic test_back_to_back();
        int v0;
        v0 = n_valid;
        sb_q.push_back('{is_err: 1'b0, data: 8'h00});
        sb_q.push_back('{is_err: 1'b0, data: 8'hFF});
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        step(2 * N);
        n_vectors++;
        if (n_valid - v0 !== 2) begin
            n_miscompares++;
            $display("FAIL back_to_back_count: valid=%0d, expected 2", n_valid - v0);
        end else $display("back-to-back 00,FF: count ok");
    endtask

    task automatic test_glitch();
        int v0, f0;
        bit saw_busy;
        v0 = n_valid; f0 = n_ferr;
        saw_busy = 1'b0;
        u_if.rx = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) u_if.rx = 1'b1;
            step(1);
            if (u_if.busy) saw_busy = 1'b1;
        end
        n_vectors++;
        if (saw_busy !== 1'b1) begin
            n_miscompares++;
            $display("FAIL glitch_start: busy never rose, expected 1");
        end else $display("glitch: start seen ok");
        step(N);
        n_vectors++;
        if (u_if.busy !== 1'b0 || n_valid !== v0 || n_ferr !== f0 || u_if.rx_data !== 8'hFF) begin
            n_miscompares++;
            $display("FAIL glitch_reject: busy=%0b valid+%0d ferr+%0d data=%02h, expected 0 0 0 FF",
                     u_if.busy, n_valid - v0, n_ferr - f0, u_if.rx_data);
        end else $display("glitch: rejected ok");
    endtask

    task automatic test_frame_err();
        int f0;
        sb_q.push_back('{is_err: 1'b0, data: 8'h3C});
        send_byte(8'h3C, 1'b1);
        f0 = n_ferr;
        sb_q.push_back('{is_err: 1'b1, data: 8'h3C});
        send_byte(8'h55, 1'b0);
        u_if.rx = 1'b0;
        step(2 * N);
        n_vectors++;
        if (u_if.busy !== 1'b0 || n_ferr - f0 !== 1) begin
            n_miscompares++;
            $display("FAIL held_low_idle: busy=%0b ferr=%0d, expected 0 1", u_if.busy, n_ferr - f0);
        end else $display("frame error: held-low line ignored ok");
        u_if.rx = 1'b1;
        step(N);
        sb_q.push_back('{is_err: 1'b0, data: 8'h81});
        send_byte(8'h81, 1'b1);
        step(2 * N);
        n_vectors++;
        if (u_if.rx_data !== 8'h81) begin
            n_miscompares++;
            $display("FAIL after_err_data: data=%02h, expected 81", u_if.rx_data);
        end else $display("after error 0x81: data ok");
    endtask

    task automatic test_reset_mid_frame();
        int v0;
        v0 = n_valid;
        fork
            send_byte(8'h99, 1'b1);
            begin
                step(5 * N + N / 2);
                #2;
                rst_n = 1'b0;
            end
        join
        n_vectors++;
        if (u_if.busy !== 1'b0 || u_if.rx_data !== 8'h00) begin
            n_miscompares++;
            $display("FAIL mid_reset_state: busy=%0b data=%02h, expected 0 00", u_if.busy, u_if.rx_data);
        end else $display("mid-frame reset: cleared ok");
        step(2);
        rst_n = 1'b1;
        step(N);
        n_vectors++;
        if (u_if.busy !== 1'b0 || n_valid !== v0) begin
            n_miscompares++;
            $display("FAIL mid_reset_abort: busy=%0b valid+%0d, expected 0 0", u_if.busy, n_valid - v0);
        end else $display("mid-frame reset: no pulse ok");
        sb_q.push_back('{is_err: 1'b0, data: 8'h7E});
        send_byte(8'h7E, 1'b1);
        step(2 * N);
        n_vectors++;
        if (n_valid - v0 !== 1 || u_if.rx_data !== 8'h7E) begin
            n_miscompares++;
            $display("FAIL post_reset_frame: valid+%0d data=%02h, expected 1 7E", n_valid - v0, u_if.rx_data);
        end else $display("post-reset 0x7E: ok");
    endtask

    task automatic test_all_bytes();
        int v0, f0;
        v0 = n_valid; f0 = n_ferr;
        for (int b = 0; b < 256; b++) begin
            sb_q.push_back('{is_err: 1'b0, data: 8'(b)});
            send_byte(8'(b), 1'b1);
        end
        step(2 * N);
        n_vectors++;
        if (n_valid - v0 !== 256 || n_ferr - f0 !== 0) begin
            n_miscompares++;
            $display("FAIL all_bytes_counts: valid=%0d ferr=%0d, expected 256 0", n_valid - v0, n_ferr - f0);
        end else $display("all bytes 00..FF: counts ok");
    endtask

    initial begin
        n_vectors     = 0;
        n_miscompares = 0;
        n_valid       = 0;
        n_ferr        = 0;
        mon_prev_data = 8'h00;
        rst_n         = 1'b0;
        u_if.rx       = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid_frame();
        test_all_bytes();
        n_vectors++;
        if (sb_q.size() !== 0) begin
            n_miscompares++;
            $display("FAIL scoreboard_drain: %0d expected frames never seen, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end
endmodule
